data_receiver: RTL

- Serial receiver for the three-wire link driven by data_transmitter: transmission (frame enable), clock (serial clock) and data.
- Synchronises the three lines into the clk domain and shifts in one WIDTH-bit word per frame.
- Presents each good word in parallel with a one-cycle valid strobe; flags short, long and stalled frames.
- Sits on the receiving board (or in loopback on the same FPGA) ahead of pulse/timestamp consumers.

---
 rtl/data_receiver_pkg.sv | 18 +
 rtl/data_receiver_sync.sv | 36 +++
 rtl/data_receiver.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/data_receiver_pkg.sv
// Shared constants for the serial link: error codes, default word width
// and the receiver state encoding.
package data_receiver_pkg;

    localparam int DEFAULT_WIDTH = 64;

    localparam logic [1:0] RX_ERR_NONE     = 2'd0;
    localparam logic [1:0] RX_ERR_SHORT    = 2'd1;
    localparam logic [1:0] RX_ERR_OVERFLOW = 2'd2;
    localparam logic [1:0] RX_ERR_TIMEOUT  = 2'd3;

    typedef enum logic [1:0] {
        ST_WAIT_IDLE = 2'd0,
        ST_IDLE      = 2'd1,
        ST_RECV      = 2'd2
    } rx_state_t;

endpackage

// File: rtl/data_receiver_sync.sv
// Two-flop synchroniser for an asynchronous pin plus an edge flop.
// level is the synchronised value; rise/fall compare flop 2 against flop 3.
module sync_edge_detector (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic sync_p0;
    logic sync_p1;
    logic edge_p2;

    // Metastability chain followed by the edge-detect history flop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            edge_p2 <= 1'b0;
        end else begin
            // Stage 0: capture asynchronous pin
            sync_p0 <= din;
            // Stage 1: resolved level
            sync_p1 <= sync_p0;
            // Stage 2: previous level for edge detection
            edge_p2 <= sync_p1;
        end
    end

    assign level = sync_p1;
    assign rise  = sync_p1 & ~edge_p2;
    assign fall  = ~sync_p1 & edge_p2;

endmodule

// File: rtl/data_receiver.sv
// Serial word receiver for the transmission/sclk/sdata link. Shifts in one
// MSB-first word per frame and reports good words and rejected frames.
module data_receiver
    import data_receiver_pkg::*;
#(
    parameter int WIDTH          = DEFAULT_WIDTH,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             transmission,
    input  logic             sclk,
    input  logic             sdata,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic             frame_error,
    output logic [1:0]       error_code,
    output logic             busy
);

    localparam int BCW = $clog2(WIDTH + 1);
    localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [BCW-1:0] BIT_FULL = BCW'(WIDTH);
    localparam logic [TCW-1:0] TMO_MAX  = TCW'(TIMEOUT_CYCLES);

    logic tx_level, tx_rise, tx_fall;
    logic sclk_rise;
    logic sdata_level;
    logic unused_sclk_level, unused_sclk_fall;
    logic unused_sdata_rise, unused_sdata_fall;

    sync_edge_detector u_sync_tx (
        .clk   (clk),
        .rst   (rst),
        .din   (transmission),
        .level (tx_level),
        .rise  (tx_rise),
        .fall  (tx_fall)
    );

    sync_edge_detector u_sync_sclk (
        .clk   (clk),
        .rst   (rst),
        .din   (sclk),
        .level (unused_sclk_level),
        .rise  (sclk_rise),
        .fall  (unused_sclk_fall)
    );

    sync_edge_detector u_sync_sdata (
        .clk   (clk),
        .rst   (rst),
        .din   (sdata),
        .level (sdata_level),
        .rise  (unused_sdata_rise),
        .fall  (unused_sdata_fall)
    );

    rx_state_t        state, state_d;
    logic [WIDTH-1:0] shreg, shreg_d;
    logic [BCW-1:0]   bcount, bcount_d;
    logic [TCW-1:0]   tcount, tcount_d;
    logic [WIDTH-1:0] data_out_d;
    logic             data_valid_d, frame_error_d, busy_d;
    logic [1:0]       error_code_d;

    // The synchronisers come out of reset at 0, so their level is not yet the
    // pin value. Hold WAIT_IDLE until the chain has refilled; otherwise a
    // frame still in progress across reset would look like an idle line.
    logic [1:0] settle;
    logic       settled;
    assign settled = (settle == 2'd3);

    // Next-state, datapath and output decode for the frame FSM.
    always_comb begin
        state_d       = state;
        shreg_d       = shreg;
        bcount_d      = bcount;
        tcount_d      = tcount;
        data_out_d    = data_out;
        data_valid_d  = 1'b0;
        frame_error_d = 1'b0;
        error_code_d  = error_code;

        case (state)
            ST_WAIT_IDLE: begin
                if (settled && !tx_level) begin
                    state_d = ST_IDLE;
                end
            end

            ST_IDLE: begin
                if (tx_rise) begin
                    shreg_d  = '0;
                    bcount_d = '0;
                    tcount_d = '0;
                    state_d  = ST_RECV;
                end
            end

            ST_RECV: begin
                if (sclk_rise && (bcount == BIT_FULL)) begin
                    frame_error_d = 1'b1;
                    error_code_d  = RX_ERR_OVERFLOW;
                    state_d       = ST_WAIT_IDLE;
                end else begin
                    if (sclk_rise) begin
                        shreg_d  = {shreg[WIDTH-2:0], sdata_level};
                        bcount_d = bcount + 1'b1;
                        tcount_d = '0;
                    end else begin
                        tcount_d = tcount + 1'b1;
                    end

                    // A bit arriving with the frame end counts toward the word.
                    if (tx_fall) begin
                        if (bcount_d == BIT_FULL) begin
                            data_out_d   = shreg_d;
                            data_valid_d = 1'b1;
                        end else begin
                            frame_error_d = 1'b1;
                            error_code_d  = RX_ERR_SHORT;
                        end
                        state_d = ST_IDLE;
                    end else if (!sclk_rise && (tcount_d == TMO_MAX)) begin
                        frame_error_d = 1'b1;
                        error_code_d  = RX_ERR_TIMEOUT;
                        state_d       = ST_WAIT_IDLE;
                    end
                end
            end

            default: begin
                state_d = ST_WAIT_IDLE;
            end
        endcase

        busy_d = (state_d == ST_RECV);
    end

    // Control state, counters and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_WAIT_IDLE;
            bcount      <= '0;
            tcount      <= '0;
            settle      <= 2'd0;
            data_out    <= '0;
            data_valid  <= 1'b0;
            frame_error <= 1'b0;
            error_code  <= RX_ERR_NONE;
            busy        <= 1'b0;
        end else begin
            state       <= state_d;
            bcount      <= bcount_d;
            tcount      <= tcount_d;
            settle      <= settled ? settle : settle + 2'd1;
            data_out    <= data_out_d;
            data_valid  <= data_valid_d;
            frame_error <= frame_error_d;
            error_code  <= error_code_d;
            busy        <= busy_d;
        end
    end

    // Shift register is cleared at every frame start, so it needs no reset.
    always_ff @(posedge clk) begin
        shreg <= shreg_d;
    end

endmodule
